// File: rtl/wishbone_if.sv
// Wishbone pipelined bus bundle.
// Signal names are from the master's point of view.
interface wishbone_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic              we_o;
  logic              stb_o;
  logic              cyc_o;
  logic              ack_i;
  logic              stall_i;
  logic [DATA_W-1:0] dat_i;

  modport master (
    output adr_o, dat_o, we_o, stb_o, cyc_o,
    input  ack_i, stall_i, dat_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, stb_o, cyc_o,
    output ack_i, stall_i, dat_i
  );
endinterface

// File: rtl/wishbone_board_ram.sv
// Minesweeper board-state RAM behind the Wishbone arbiter,
// with a stalling clear engine for new-game initialisation.
module wishbone_board_ram #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 16,
  parameter int          ACK_LAT   = 1,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  wishbone_if.slave  bus,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic       clr_done
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              stall_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              a1, a2;
  logic [DATA_W-1:0] d1, d2;

  assign accept   = bus.cyc_o & bus.stb_o & ~stall_q;
  assign bus.stall_i = stall_q;
  assign clr_busy = stall_q;

  // Array is never reset; only the sweep initialises it.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt] <= CLR_VALUE;
    else if (accept && bus.we_o)
      mem[bus.adr_o] <= bus.dat_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      stall_q  <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            cnt     <= '0;
            stall_q <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state    <= IDLE;
            stall_q  <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= 1'b0;
      a2 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      if (!bus.cyc_o) begin
        a1 <= 1'b0;
        a2 <= 1'b0;
      end else begin
        a1 <= accept;
        a2 <= a1;
      end
      if (accept)
        d1 <= mem[bus.adr_o];
      d2 <= d1;
    end
  end

  // Qualify with cyc so an abandoned cycle never sees a stale ack.
  assign bus.ack_i = ((ACK_LAT == 2) ? a2 : a1) & bus.cyc_o;
  assign bus.dat_i = (ACK_LAT == 2) ? d2 : d1;

endmodule

// File: tb/tb_wishbone_board_ram.sv
// Directed bench for wishbone_board_ram.
// Two instances (ACK_LAT 1 and 2) share identical stimulus.
module tb_wishbone_board_ram;
  logic clk;
  logic rst_n;
  logic clr_start;
  logic busy_a, done_a, busy_b, done_b;
  int   checks;
  int   errors;

  wishbone_if #(.ADDR_W(8), .DATA_W(16)) wa ();
  wishbone_if #(.ADDR_W(8), .DATA_W(16)) wb ();

  wishbone_board_ram #(.ACK_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(wa),
    .clr_start(clr_start),
    .clr_busy(busy_a), .clr_done(done_a)
  );

  wishbone_board_ram #(.ACK_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(wb),
    .clr_start(clr_start),
    .clr_busy(busy_b), .clr_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cyc, input logic stb,
                       input logic we, input logic [7:0] adr,
                       input logic [15:0] dat);
    wa.cyc_o = cyc; wa.stb_o = stb; wa.we_o = we;
    wa.adr_o = adr; wa.dat_o = dat;
    wb.cyc_o = cyc; wb.stb_o = stb; wb.we_o = we;
    wb.adr_o = adr; wb.dat_o = dat;
  endtask

  // One accepted request; returns #1 after the accept edge.
  task automatic req(input logic we, input logic [7:0] adr,
                     input logic [15:0] dat);
    drive(1'b1, 1'b1, we, adr, dat);
    tick();
    drive(1'b1, 1'b0, we, adr, dat);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (wa.stall_i && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (wa.stall_i !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle stall=%b required 0", wa.stall_i);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_start = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    tick();
    checks++;
    if (wa.ack_i !== 1'b0) begin
      errors++; $display("FAIL rst_ack got %b want 0", wa.ack_i);
    end
    checks++;
    if (wa.stall_i !== 1'b0) begin
      errors++; $display("FAIL rst_stall got %b want 0", wa.stall_i);
    end
    checks++;
    if (wa.dat_i !== 16'h0000) begin
      errors++; $display("FAIL rst_dat got %h want 0000", wa.dat_i);
    end
    checks++;
    if ({busy_a, done_a, busy_b, done_b} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_clr got %b want 0000",
               {busy_a, done_a, busy_b, done_b});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 1'b1, 8'h10, 16'hA5A5);
    tick();
    checks++;
    if (wa.ack_i !== 1'b1) begin
      errors++; $display("FAIL wr_ack got %b want 1", wa.ack_i);
    end
    drive(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
    checks++;
    if (wa.ack_i !== 1'b1 || wa.dat_i !== 16'hA5A5) begin
      errors++;
      $display("FAIL rd_ack ack=%b dat=%h want 1 a5a5",
               wa.ack_i, wa.dat_i);
    end
    tick();
    checks++;
    if (wa.ack_i !== 1'b0) begin
      errors++; $display("FAIL rd_single got %b want 0", wa.ack_i);
    end
    idle();
  endtask

  task automatic test_burst();
    logic [7:0]  adr;
    logic [15:0] exp;
    for (int k = 0; k < 10; k++) begin
      if (k < 4)
        drive(1'b1, 1'b1, 1'b1, 8'h20 + 8'(k), 16'h0100 + 16'(k));
      else if (k < 8)
        drive(1'b1, 1'b1, 1'b0, 8'h20 + 8'(k - 4), 16'h0000);
      else
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      checks++;
      if (wa.ack_i !== (k <= 7)) begin
        errors++;
        $display("FAIL burst_a_ack k=%0d got %b want %b",
                 k, wa.ack_i, (k <= 7));
      end
      checks++;
      if (wb.ack_i !== (k >= 1 && k <= 8)) begin
        errors++;
        $display("FAIL burst_b_ack k=%0d got %b want %b",
                 k, wb.ack_i, (k >= 1 && k <= 8));
      end
      if (k >= 4 && k <= 7) begin
        exp = 16'h0100 + 16'(k - 4);
        checks++;
        if (wa.dat_i !== exp) begin
          errors++;
          $display("FAIL burst_a_dat k=%0d got %h want %h",
                   k, wa.dat_i, exp);
        end
      end
      if (k >= 5 && k <= 8) begin
        exp = 16'h0100 + 16'(k - 5);
        checks++;
        if (wb.dat_i !== exp) begin
          errors++;
          $display("FAIL burst_b_dat k=%0d got %h want %h",
                   k, wb.dat_i, exp);
        end
      end
    end
    adr = 8'h00;
    idle();
  endtask

  task automatic test_abandon();
    drive(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000);
    #1;
    checks++;
    if (wa.ack_i !== 1'b0) begin
      errors++; $display("FAIL abandon1_a got %b want 0", wa.ack_i);
    end
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
    tick();
    checks++;
    if (wb.ack_i !== 1'b0) begin
      errors++; $display("FAIL abandon2_b0 got %b want 0", wb.ack_i);
    end
    drive(1'b1, 1'b1, 1'b0, 8'h11, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wa.ack_i !== 1'b0 || wb.ack_i !== 1'b0) begin
        errors++;
        $display("FAIL abandon2 k=%0d a=%b b=%b want 0 0",
                 k, wa.ack_i, wb.ack_i);
      end
      tick();
    end
  endtask

  task automatic test_clear();
    int n;
    int dones;
    int bad_ack;
    req(1'b1, 8'h40, 16'hDEAD);
    idle();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h40, 16'h0000);
    n = 0; dones = 0; bad_ack = 0;
    while (wa.stall_i && n < 400) begin
      if (!busy_a) bad_ack++;
      if (wa.ack_i || wb.ack_i) bad_ack++;
      if (done_a) dones++;
      n++;
      tick();
    end
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL clr_len got %0d want 256", n);
    end
    checks++;
    if (bad_ack !== 0 || dones !== 0) begin
      errors++;
      $display("FAIL clr_sweep bad=%0d done=%0d want 0 0",
               bad_ack, dones);
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || wa.ack_i !== 1'b0) begin
      errors++;
      $display("FAIL clr_done done=%b busy=%b ack=%b want 1 0 0",
               done_a, busy_a, wa.ack_i);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h40, 16'h0000);
    checks++;
    if (wa.ack_i !== 1'b1 || wa.dat_i !== 16'h0000 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL clr_rd_a ack=%b dat=%h done=%b want 1 0000 0",
               wa.ack_i, wa.dat_i, done_a);
    end
    tick();
    checks++;
    if (wb.ack_i !== 1'b1 || wb.dat_i !== 16'h0000) begin
      errors++;
      $display("FAIL clr_rd_b ack=%b dat=%h want 1 0000",
               wb.ack_i, wb.dat_i);
    end
    idle();
  endtask

  task automatic test_simultaneous();
    clr_start = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'h30, 16'h1234);
    tick();
    clr_start = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h30, 16'h0000);
    checks++;
    if (wa.ack_i !== 1'b1 || wa.stall_i !== 1'b1) begin
      errors++;
      $display("FAIL sim_ack ack=%b stall=%b want 1 1",
               wa.ack_i, wa.stall_i);
    end
    tick();
    checks++;
    if (wb.ack_i !== 1'b1) begin
      errors++; $display("FAIL sim_ack_b got %b want 1", wb.ack_i);
    end
    wait_idle();
    req(1'b0, 8'h30, 16'h0000);
    checks++;
    if (wa.ack_i !== 1'b1 || wa.dat_i !== 16'h0000) begin
      errors++;
      $display("FAIL sim_rd ack=%b dat=%h want 1 0000",
               wa.ack_i, wa.dat_i);
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int dones;
    req(1'b1, 8'h80, 16'hBEEF);
    req(1'b1, 8'h10, 16'h5555);
    idle();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wa.ack_i, wa.stall_i, busy_a, done_a} !== 4'b0000 ||
        wa.dat_i !== 16'h0000) begin
      errors++;
      $display("FAIL midrst ack/stall/busy/done=%b dat=%h want 0000 0000",
               {wa.ack_i, wa.stall_i, busy_a, done_a}, wa.dat_i);
    end
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 300; k++) begin
      if (done_a || wa.stall_i) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL midrst_done got %0d want 0", dones);
    end
    req(1'b0, 8'h10, 16'h0000);
    checks++;
    if (wa.ack_i !== 1'b1 || wa.dat_i !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_swept ack=%b dat=%h want 1 0000",
               wa.ack_i, wa.dat_i);
    end
    req(1'b0, 8'h80, 16'h0000);
    checks++;
    if (wa.ack_i !== 1'b1 || wa.dat_i !== 16'hBEEF) begin
      errors++;
      $display("FAIL midrst_kept ack=%b dat=%h want 1 beef",
               wa.ack_i, wa.dat_i);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_burst();
    test_abandon();
    test_clear();
    test_simultaneous();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
